instr_decoder_pipe: RTL

- Parametrised, pipelined successor of the 8-bit instruction decoder for the course microprocessor.
- Sits between program memory (next_instr) and the datapath/program sequencer.
- Adds the following over the previous decoder:
  - valid/stall/flush pipeline control
  - an optional registered decode stage
  - a programmable NOP set
  - saturating retired-instruction and NOP performance counters

---
 rtl/instr_decoder_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_decoder_pipe.sv
// Pipelined 8-bit instruction decoder for the course microprocessor.
// Latches instruction words from program memory into ir under valid/stall/flush
// control, decodes them into datapath control signals (optionally through a
// registered stage) and keeps saturating retired-instruction and NOP counters.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   next_instr         instruction word from program memory
//   instr_valid        next_instr is valid this cycle
//   stall, flush       hold the pipeline / discard the current slot
//   ir, ir_nibble      instruction register and its immediate nibble
//   dec_valid          decode outputs describe a real instruction
//   jmp, jmp_nz        unconditional / not-zero jump
//   i_sel, x_sel, y_sel, source_sel, reg_en, from_ID   datapath controls
//   nop_hit            current instruction is one of the NOP opcodes
//   retired_cnt, nop_cnt  saturating performance counters
module instr_decoder_pipe #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEC_REG = 0,
  parameter logic [7:0]  NOP0    = 8'hC8,
  parameter logic [7:0]  NOP1    = 8'hCF,
  parameter logic [7:0]  NOP2    = 8'hD8,
  parameter logic [7:0]  NOP3    = 8'hDF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       next_instr,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [7:0]       ir,
  output logic             dec_valid,
  output logic [3:0]       ir_nibble,
  output logic             jmp,
  output logic             jmp_nz,
  output logic             i_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic [3:0]       source_sel,
  output logic [8:0]       reg_en,
  output logic [7:0]       from_ID,
  output logic             nop_hit,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] nop_cnt
);

  typedef struct packed {
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic       jmp;
    logic       jmp_nz;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic       nop_hit;
  } dec_t;

  localparam dec_t DEC_RST = '{reg_en: 9'h1FF, source_sel: 4'd10, jmp: 1'b0,
                               jmp_nz: 1'b0, i_sel: 1'b0, x_sel: 1'b0,
                               y_sel: 1'b0, nop_hit: 1'b0};
  localparam dec_t DEC_BUB = '{reg_en: 9'h000, source_sel: 4'd0, jmp: 1'b0,
                               jmp_nz: 1'b0, i_sel: 1'b0, x_sel: 1'b0,
                               y_sel: 1'b0, nop_hit: 1'b0};

  function automatic logic is_nop(input logic [7:0] op);
    return (op == NOP0) || (op == NOP1) || (op == NOP2) || (op == NOP3);
  endfunction

  // Destination code 4 selects the o_reg enable (bit 8); bit 4 belongs to the ALU.
  function automatic logic [8:0] dest_onehot(input logic [2:0] d);
    return (d == 3'd4) ? 9'h100 : (9'h001 << d);
  endfunction

  function automatic dec_t decode(input logic [7:0] op, input logic v);
    dec_t       d;
    logic [2:0] dst;
    logic [2:0] src;
    d   = DEC_BUB;
    dst = op[6:4];
    src = op[2:0];
    if (v) begin
      d.i_sel   = 1'b1;
      d.nop_hit = is_nop(op);
      if (!op[7]) begin
        // load immediate
        d.reg_en     = dest_onehot(dst);
        d.reg_en[6]  = d.reg_en[6] | (dst == 3'd7);
        d.source_sel = 4'd8;
        d.i_sel      = (dst != 3'd6);
      end else if (!op[6]) begin
        // register move
        dst          = op[5:3];
        d.reg_en     = dest_onehot(dst);
        d.reg_en[6]  = d.reg_en[6] | (dst == 3'd7) | (src == 3'd7);
        if (src == 3'd4)
          d.source_sel = 4'd4;
        else if (src == dst)
          d.source_sel = 4'd9;
        else
          d.source_sel = {1'b0, src};
        d.i_sel      = (dst != 3'd6);
      end else if (!op[5]) begin
        // ALU operation
        d.reg_en[4]  = 1'b1;
        d.x_sel      = op[4];
        d.y_sel      = op[3];
        d.source_sel = {1'b0, src};
      end else begin
        // jumps
        d.jmp        = ~op[4];
        d.jmp_nz     = op[4];
        d.source_sel = {1'b0, src};
      end
    end
    return d;
  endfunction

  logic [7:0]       ir_q;
  logic             dv_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] nop_q;

  // Fetch stage: flush beats stall beats instr_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q      <= NOP0;
      dv_q      <= 1'b0;
      retired_q <= '0;
      nop_q     <= '0;
    end else if (flush) begin
      dv_q <= 1'b0;
    end else if (!stall) begin
      if (instr_valid) begin
        ir_q <= next_instr;
        dv_q <= 1'b1;
        if (retired_q != '1)
          retired_q <= retired_q + CNT_W'(1);
        if (is_nop(next_instr) && (nop_q != '1))
          nop_q <= nop_q + CNT_W'(1);
      end else begin
        dv_q <= 1'b0;
      end
    end
  end

  dec_t       dec_c;
  dec_t       dec_o;
  logic [7:0] ir_o;
  logic       dv_o;

  assign dec_c = decode(ir_q, dv_q);

  if (DEC_REG != 0) begin : g_reg
    dec_t       dec_q;
    logic [7:0] ir_d;
    logic       dv_d;

    // Registered decode; ir/dec_valid travel alongside to stay aligned.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dec_q <= DEC_RST;
        ir_d  <= NOP0;
        dv_d  <= 1'b0;
      end else if (flush) begin
        dec_q <= DEC_BUB;
        ir_d  <= ir_q;
        dv_d  <= 1'b0;
      end else if (!stall) begin
        dec_q <= dec_c;
        ir_d  <= ir_q;
        dv_d  <= dv_q;
      end
    end

    assign dec_o = dec_q;
    assign ir_o  = ir_d;
    assign dv_o  = dv_d;
  end else begin : g_comb
    // Reset pattern must appear asynchronously even though decode is combinational.
    assign dec_o = reset ? DEC_RST : dec_c;
    assign ir_o  = ir_q;
    assign dv_o  = dv_q;
  end

  assign ir          = ir_o;
  assign dec_valid   = dv_o;
  assign ir_nibble   = ir_o[3:0];
  assign jmp         = dec_o.jmp;
  assign jmp_nz      = dec_o.jmp_nz;
  assign i_sel       = dec_o.i_sel;
  assign x_sel       = dec_o.x_sel;
  assign y_sel       = dec_o.y_sel;
  assign source_sel  = dec_o.source_sel;
  assign reg_en      = dec_o.reg_en;
  assign from_ID     = dec_o.reg_en[7:0];
  assign nop_hit     = dec_o.nop_hit;
  assign retired_cnt = retired_q;
  assign nop_cnt     = nop_q;

endmodule
